// File: rtl/edge_evt_pkg.sv
// rtl/edge_evt_pkg.sv - shared types, defaults and round-robin search for edge_evt_arb
package edge_evt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_PEND_W = 2;

    // Search width is fixed so one function serves every channel count up to MAX_CH.
    localparam int MAX_CH = 32;
    localparam int IDX_W  = 5;

    // First requesting index at or after ptr, wrapping at n; 0 when nothing requests.
    function automatic logic [IDX_W-1:0] rr_search(
        input logic [MAX_CH-1:0] req,
        input int                n,
        input logic [IDX_W-1:0]  ptr
    );
        logic [IDX_W-1:0] win;
        int               idx;
        win = '0;
        // Walk the window backwards so the earliest position in search order wins.
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[IDX_W-1:0]]) begin
                    win = idx[IDX_W-1:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/edge_evt_ch.sv
// rtl/edge_evt_ch.sv - one channel: edge detector, saturating pending counter, overflow pulse (EDGE_BOTH_EN)
module edge_evt_ch #(
    parameter int PEND_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic grant,
    output logic pending,
    output logic ovf
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic              prev;
    logic              edge_det;
    logic [PEND_W-1:0] cnt;

    // prev follows level even in reset so a level already high is not seen as an edge.
    always_ff @(posedge clk) begin
        prev <= level;
    end

`ifdef EDGE_BOTH_EN
    assign edge_det = level ^ prev;
`else
    assign edge_det = level & ~prev;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case ({edge_det, grant})
                2'b10: begin
                    if (cnt == CNT_MAX) begin
                        ovf <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pending = |cnt;

endmodule

// File: rtl/edge_evt_arb.sv
// rtl/edge_evt_arb.sv - multi-channel edge-event scheduler with round-robin output (EDGE_BOTH_EN)
module edge_evt_arb
    import edge_evt_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int PEND_W = DEF_PEND_W,
    parameter int ID_W   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] level,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N_CH-1:0] ovf
);

    state_t            state;
    state_t            state_nxt;
    logic [N_CH-1:0]   nonzero;
    logic [N_CH-1:0]   grant;
    logic [MAX_CH-1:0] req_pad;
    logic [IDX_W-1:0]  win_full;
    logic [IDX_W-1:0]  win_inc;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_nxt;
    logic              any_pend;
    logic              load;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_evt_ch #(
            .PEND_W(PEND_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .level   (level[i]),
            .grant   (grant[i]),
            .pending (nonzero[i]),
            .ovf     (ovf[i])
        );
    end

    always_comb begin
        req_pad = '0;
        req_pad[N_CH-1:0] = nonzero;
    end

    assign any_pend = |nonzero;
    assign win_full = rr_search(req_pad, N_CH, IDX_W'(rr_ptr));
    assign win_id   = win_full[ID_W-1:0];
    assign win_inc  = win_full + 1'b1;
    assign rr_nxt   = (win_full == IDX_W'(N_CH - 1)) ? '0 : win_inc[ID_W-1:0];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    load      = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (evt_ready) begin
                    if (any_pend) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loading an event is the grant: the winner's counter gives up one entry this cycle.
    always_comb begin
        grant = '0;
        if (load) begin
            grant[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            evt_id <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                evt_id <= win_id;
                rr_ptr <= rr_nxt;
            end
        end
    end

    assign evt_valid = (state == VALID);

endmodule

// File: tb/tb_edge_evt_arb.sv
// tb/tb_edge_evt_arb.sv - scoreboard bench for edge_evt_arb against a behavioural model
module tb_edge_evt_arb;

    localparam int N    = 4;
    localparam int PMAX = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] level = '0;
    logic         evt_ready = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [N-1:0] ovf;

    always #5 clk = ~clk;

    edge_evt_arb dut (
        .clk       (clk),
        .rst       (rst),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .ovf       (ovf)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    int       pend[N];
    bit       m_valid = 1'b0;
    int       rr = 0;
    bit [N-1:0] m_prev = '0;
    bit [N-1:0] m_ovf = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: per-channel pending counts, one output slot, round-robin pointer.
    always @(posedge clk) begin : model
        bit [N-1:0] e;
        int g;
        if (rst) begin
            m_prev = level;
            for (int i = 0; i < N; i++) pend[i] = 0;
            m_valid = 1'b0;
            rr = 0;
            m_ovf = '0;
            exp_q.delete();
        end else begin
`ifdef EDGE_BOTH_EN
            e = level ^ m_prev;
`else
            e = level & ~m_prev;
`endif
            m_prev = level;
            g = -1;
            if (!m_valid || evt_ready) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && pend[(rr + k) % N] > 0) g = (rr + k) % N;
                if (g >= 0) begin
                    m_valid = 1'b1;
                    rr = (g + 1) % N;
                    exp_q.push_back(g);
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_ovf = '0;
            for (int i = 0; i < N; i++) begin
                if (e[i] && g != i) begin
                    if (pend[i] == PMAX) m_ovf[i] = 1'b1;
                    else pend[i]++;
                end else if (!e[i] && g == i) begin
                    pend[i]--;
                end
            end
        end
    end

    bit         p_valid = 1'b0;
    bit         p_ready = 1'b0;
    bit         p_rst = 1'b1;
    logic [1:0] p_id = '0;

    always @(negedge clk) begin : monitor
        chk("evt_valid", int'(evt_valid), int'(m_valid));
        chk("ovf", int'(ovf), int'(m_ovf));
        if (p_valid && !p_ready && !p_rst && evt_valid)
            chk("evt_id_hold", int'(evt_id), int'(p_id));
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", 1, 0);
            end else begin
                chk("evt_id", int'(evt_id), exp_q.pop_front());
            end
        end
        p_valid = evt_valid;
        p_ready = evt_ready;
        p_rst   = rst;
        p_id    = evt_id;
    end

    task automatic step(input logic [N-1:0] lv, input logic rdy, input logic r);
        level     = lv;
        evt_ready = rdy;
        rst       = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] lv;
        repeat (4) step(4'hF, 1'b1, 1'b1);
        step(4'hF, 1'b1, 1'b0);
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_id", int'(evt_id), 0);
        chk("reset_ovf", int'(ovf), 0);
        repeat (4) step(4'hF, 1'b1, 1'b0);
        repeat (3) step(4'h0, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        repeat (3) step(4'h0, 1'b1, 1'b0);
        step(4'hF, 1'b1, 1'b0);
        repeat (6) step(4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
        end
        repeat (8) step(4'h0, 1'b1, 1'b0);
        for (int c = 0; c < 16; c++)
            step((c % 2) ? 4'b1001 : 4'b0000, 1'(c % 2), 1'b0);
        repeat (6) step(4'h0, 1'b1, 1'b0);
        lv = '0;
        for (int c = 0; c < 3000; c++) begin
            lv = 4'($urandom_range(0, 15));
            step(lv, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
        end
        repeat (40) step(lv, 1'b1, 1'b0);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_valid", int'(evt_valid), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
